fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch stage: drives the PC register's reset, enable
//  and branch-mux select/target, plus the IF/ID register enable and flush.
//  Arbitrates boot hold, hazard-unit stalls, EX-stage redirects and halt/resume.
//  Keeps saturating perf counters for stall cycles and redirects.
// PARAMETERS
//  XLEN          32  PC/target width
//  BOOT_CYCLES   2   cycles pcRst held after rst deasserts (>=1)
//  FLUSH_CYCLES  1   cycles ifIdFlush asserted per redirect, including redirect cycle (>=1)
//  CNT_W         16  perf counter width
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst             in   1      synchronous, active-high reset
//  stallReq        in   1      hazard unit: hold PC and IF/ID this cycle
//  redirectReq     in   1      taken branch/jump resolved in EX
//  redirectTarget  in   XLEN   target PC, valid with redirectReq
//  haltReq         in   1      halt fetch (ebreak decoded / debug)
//  resumeReq       in   1      leave HALT
//  pcRst           out  1      to PC register reset
//  pcEn            out  1      to PC register enable
//  branchSel       out  1      1 = PC loads branchVal, 0 = PC+4
//  branchVal       out  XLEN   PC load target
//  ifIdEn          out  1      IF/ID pipeline register enable
//  ifIdFlush       out  1      IF/ID pipeline register clear (bubble)
//  halted          out  1      1 while in HALT
//  stallCnt        out  CNT_W  saturating count of cycles in which a stall is applied
//  redirCnt        out  CNT_W  saturating count of applied redirects
// BEHAVIOUR
//  States: BOOT, RUN, FLUSH, HALT. Registered: state, bootCnt, flushCnt, pendValid,
//   pendTarget, stallCnt, redirCnt. All other outputs are combinational (Mealy), so
//   a redirect loads the PC at the same edge that samples redirectReq.
//  Reset (rst=1): state=BOOT, bootCnt=BOOT_CYCLES-1, pendValid=0, pendTarget=0,
//   counters=0. Outputs while rst=1: pcRst=1, pcEn=0, branchSel=0, branchVal=0,
//   ifIdEn=0, ifIdFlush=1, halted=0.
//  Output defaults (any state): branchVal=0, branchSel=0.
//  BOOT: pcRst=1, pcEn=0, ifIdEn=0, ifIdFlush=1. bootCnt decrements; at 0 -> RUN.
//   redirectReq in BOOT is latched into pendTarget (pendValid=1). haltReq, stallReq
//   and resumeReq are ignored in BOOT.
//  RUN, priority redirect > halt > stall:
//   live redirectReq: pcEn=1, branchSel=1, branchVal=redirectTarget, ifIdEn=1,
//    ifIdFlush=1, redirCnt++, pendValid cleared; -> FLUSH if FLUSH_CYCLES>1,
//    flushCnt=FLUSH_CYCLES-2; otherwise stays RUN. stallReq/haltReq dropped this cycle.
//   else pendValid: same as live redirect using pendTarget; pendValid cleared.
//   else haltReq: pcEn=0, ifIdEn=0, ifIdFlush=0; -> HALT.
//   else stallReq: pcEn=0, ifIdEn=0, ifIdFlush=0, stallCnt++.
//   else: pcEn=1, ifIdEn=1, ifIdFlush=0, branchSel=0.
//  FLUSH: pcEn=0 (PC held at target), ifIdEn=1, ifIdFlush=1. flushCnt decrements;
//   at 0 -> RUN. A new redirectReq is applied as in RUN and restarts flushCnt.
//   haltReq in FLUSH moves to HALT at flush end; stallReq is ignored in FLUSH.
//  HALT: pcEn=0, ifIdEn=0, ifIdFlush=0, halted=1. redirectReq latches pendTarget
//   (last one wins). resumeReq -> RUN on next cycle; the pending redirect, if any,
//   is applied in that first RUN cycle. haltReq and stallReq are ignored in HALT.
//  Counters saturate at 2^CNT_W-1 and never wrap. Only rst clears them.
//  rst asserted in any state, mid-flush or mid-halt, overrides everything that cycle.
// TESTING
//  rst 1 cycle, BOOT_CYCLES=2 -> pcRst=1 for the rst cycle plus 2 cycles; pcEn=1 in
//   the 1st RUN cycle; PC sequence 0,4,8.
//  RUN, stallReq=1 for 3 cycles -> pcEn=0 and ifIdEn=0 for exactly 3 cycles,
//   PC holds at 0x8, stallCnt=3.
//  redirectReq + target 0x100 with stallReq=1 in the same cycle -> branchSel=1,
//   ifIdFlush=1, next PC=0x100, redirCnt=1, stallCnt unchanged.
//  FLUSH_CYCLES=3, redirect to 0x40 -> ifIdFlush=1 for 3 cycles, PC=0x40 held for
//   2 cycles, then 0x44.
//  haltReq -> halted=1 next cycle; redirect to 0x200 while halted; resumeReq ->
//   first RUN cycle has branchSel=1 and branchVal=0x200.
//  Preload stallCnt to 0xFFFE, hold a stall for 5 cycles -> stallCnt=0xFFFF;
//   rst mid-HALT -> BOOT, counters=0, halted=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. Drives the PC register's reset,
//                enable and branch-mux select/target, and the IF/ID register
//                enable and flush. Arbitrates boot hold, hazard stalls,
//                EX-stage redirects and halt/resume. Keeps saturating
//                performance counters for stall cycles and applied redirects.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN          PC / target width
//    BOOT_CYCLES   cycles pcRst is held after rst deasserts (>=1)
//    FLUSH_CYCLES  cycles ifIdFlush is asserted per redirect, redirect cycle
//                  included (>=1)
//    CNT_W         perf counter width
//  Ports
//    clk             in   clock, all state updates on the rising edge
//    rst             in   synchronous active-high reset
//    stallReq        in   hazard unit: hold PC and IF/ID this cycle
//    redirectReq     in   taken branch/jump resolved in EX
//    redirectTarget  in   target PC, valid with redirectReq
//    haltReq         in   halt fetch (ebreak decoded / debug)
//    resumeReq       in   leave HALT
//    pcRst           out  PC register reset
//    pcEn            out  PC register enable
//    branchSel       out  1 = PC loads branchVal, 0 = PC+4
//    branchVal       out  PC load target
//    ifIdEn          out  IF/ID pipeline register enable
//    ifIdFlush       out  IF/ID pipeline register clear (bubble)
//    halted          out  1 while in HALT
//    stallCnt        out  saturating count of applied stall cycles
//    redirCnt        out  saturating count of applied redirects
// ============================================================================
module fetch_ctrl #(
    parameter int XLEN         = 32,
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallReq,
    input  logic             redirectReq,
    input  logic [XLEN-1:0]  redirectTarget,
    input  logic             haltReq,
    input  logic             resumeReq,
    output logic             pcRst,
    output logic             pcEn,
    output logic             branchSel,
    output logic [XLEN-1:0]  branchVal,
    output logic             ifIdEn,
    output logic             ifIdFlush,
    output logic             halted,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] redirCnt
);

    // Counter widths only need to hold the reload values (N-1 and N-2).
    localparam int c_BOOT_W  = (BOOT_CYCLES > 1)  ? $clog2(BOOT_CYCLES)  : 1;
    localparam int c_FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [c_BOOT_W-1:0]  c_BOOT_RELOAD  = c_BOOT_W'(BOOT_CYCLES - 1);
    // The redirect cycle itself is the first flush cycle, so the FLUSH state
    // only has to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_RELOAD =
        c_FLUSH_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam bit c_HAS_FLUSH = (FLUSH_CYCLES > 1);

    localparam logic [c_BOOT_W-1:0]  c_BOOT_ONE  = c_BOOT_W'(1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE = c_FLUSH_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        c_ST_BOOT  = 2'd0,
        c_ST_RUN   = 2'd1,
        c_ST_FLUSH = 2'd2,
        c_ST_HALT  = 2'd3
    } fetchState_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    fetchState_t        r_state;
    logic [c_BOOT_W-1:0]  r_bootCnt;
    logic [c_FLUSH_W-1:0] r_flushCnt;
    logic               r_pendValid;
    logic [XLEN-1:0]    r_pendTarget;
    logic [CNT_W-1:0]   r_stallCnt;
    logic [CNT_W-1:0]   r_redirCnt;

    // ------------------------------------------------------------------
    // Next-state / output wires
    // ------------------------------------------------------------------
    fetchState_t        w_nextState;
    logic [c_BOOT_W-1:0]  w_nextBootCnt;
    logic [c_FLUSH_W-1:0] w_nextFlushCnt;
    logic               w_nextPendValid;
    logic [XLEN-1:0]    w_nextPendTarget;
    logic               w_incStall;
    logic               w_incRedir;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_BOOT;
            r_bootCnt    <= c_BOOT_RELOAD;
            r_flushCnt   <= '0;
            r_pendValid  <= 1'b0;
            r_pendTarget <= '0;
        end else begin
            r_state      <= w_nextState;
            r_bootCnt    <= w_nextBootCnt;
            r_flushCnt   <= w_nextFlushCnt;
            r_pendValid  <= w_nextPendValid;
            r_pendTarget <= w_nextPendTarget;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters; only rst clears them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_redirCnt <= '0;
        end else begin
            if (w_incStall && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + c_CNT_ONE;
            end
            if (w_incRedir && (r_redirCnt != c_CNT_MAX)) begin
                r_redirCnt <= r_redirCnt + c_CNT_ONE;
            end
        end
    end

    assign stallCnt = r_stallCnt;
    assign redirCnt = r_redirCnt;

    // ------------------------------------------------------------------
    // Next-state and Mealy outputs. Outputs depend on live inputs so a
    // redirect loads the PC on the same edge that samples redirectReq.
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState      = r_state;
        w_nextBootCnt    = r_bootCnt;
        w_nextFlushCnt   = r_flushCnt;
        w_nextPendValid  = r_pendValid;
        w_nextPendTarget = r_pendTarget;
        w_incStall       = 1'b0;
        w_incRedir       = 1'b0;

        pcRst     = 1'b0;
        pcEn      = 1'b0;
        branchSel = 1'b0;
        branchVal = '0;
        ifIdEn    = 1'b0;
        ifIdFlush = 1'b0;
        halted    = 1'b0;

        case (r_state)
            c_ST_BOOT: begin
                pcRst     = 1'b1;
                ifIdFlush = 1'b1;
                // A redirect arriving during boot is replayed in the first
                // RUN cycle; hazard, halt and resume requests are meaningless
                // while the PC is still held in reset.
                if (redirectReq) begin
                    w_nextPendValid  = 1'b1;
                    w_nextPendTarget = redirectTarget;
                end
                if (r_bootCnt == '0) begin
                    w_nextState = c_ST_RUN;
                end else begin
                    w_nextBootCnt = r_bootCnt - c_BOOT_ONE;
                end
            end

            c_ST_RUN: begin
                if (redirectReq || r_pendValid) begin
                    // A live redirect supersedes any pending one.
                    pcEn            = 1'b1;
                    branchSel       = 1'b1;
                    branchVal       = redirectReq ? redirectTarget : r_pendTarget;
                    ifIdEn          = 1'b1;
                    ifIdFlush       = 1'b1;
                    w_incRedir      = 1'b1;
                    w_nextPendValid = 1'b0;
                    if (c_HAS_FLUSH) begin
                        w_nextState    = c_ST_FLUSH;
                        w_nextFlushCnt = c_FLUSH_RELOAD;
                    end
                end else if (haltReq) begin
                    w_nextState = c_ST_HALT;
                end else if (stallReq) begin
                    w_incStall = 1'b1;
                end else begin
                    pcEn   = 1'b1;
                    ifIdEn = 1'b1;
                end
            end

            c_ST_FLUSH: begin
                // PC sits at the redirect target while IF/ID clocks in bubbles.
                ifIdEn    = 1'b1;
                ifIdFlush = 1'b1;
                if (redirectReq) begin
                    pcEn            = 1'b1;
                    branchSel       = 1'b1;
                    branchVal       = redirectTarget;
                    w_incRedir      = 1'b1;
                    w_nextPendValid = 1'b0;
                    w_nextFlushCnt  = c_FLUSH_RELOAD;
                end else if (r_flushCnt == '0) begin
                    // A halt seen on the last flush cycle takes effect once the
                    // bubbles are complete instead of cutting the flush short.
                    w_nextState = haltReq ? c_ST_HALT : c_ST_RUN;
                end else begin
                    w_nextFlushCnt = r_flushCnt - c_FLUSH_ONE;
                end
            end

            c_ST_HALT: begin
                halted = 1'b1;
                // Latest redirect wins; it is applied in the first RUN cycle.
                if (redirectReq) begin
                    w_nextPendValid  = 1'b1;
                    w_nextPendTarget = redirectTarget;
                end
                if (resumeReq) begin
                    w_nextState = c_ST_RUN;
                end
            end

            default: begin
                w_nextState = c_ST_BOOT;
            end
        endcase

        // Reset overrides the outputs in any state; the registers are reset
        // on the same edge, so the next-state values are irrelevant here.
        if (rst) begin
            pcRst      = 1'b1;
            pcEn       = 1'b0;
            branchSel  = 1'b0;
            branchVal  = '0;
            ifIdEn     = 1'b0;
            ifIdFlush  = 1'b1;
            halted     = 1'b0;
            w_incStall = 1'b0;
            w_incRedir = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Directed testbench for fetch_ctrl. Instance A uses the
//                default parameters (single-cycle flush, 16-bit counters);
//                instance B uses a 3-cycle flush and 3-bit counters so that
//                counter saturation is reachable in a few cycles. Each
//                instance drives a small PC register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // ---------------- instance A ----------------
    logic        aRst = 1'b1, aStall = 1'b0, aRedir = 1'b0, aHalt = 1'b0, aResume = 1'b0;
    logic [31:0] aTgt = '0;
    logic        aPcRst, aPcEn, aBranchSel, aIfIdEn, aIfIdFlush, aHalted;
    logic [31:0] aBranchVal;
    logic [15:0] aStallCnt, aRedirCnt;
    logic [31:0] aPc = '0;

    fetch_ctrl #(.XLEN(32), .BOOT_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(16)) dutA (
        .clk(clk), .rst(aRst), .stallReq(aStall), .redirectReq(aRedir),
        .redirectTarget(aTgt), .haltReq(aHalt), .resumeReq(aResume),
        .pcRst(aPcRst), .pcEn(aPcEn), .branchSel(aBranchSel), .branchVal(aBranchVal),
        .ifIdEn(aIfIdEn), .ifIdFlush(aIfIdFlush), .halted(aHalted),
        .stallCnt(aStallCnt), .redirCnt(aRedirCnt)
    );

    // ---------------- instance B ----------------
    logic        bRst = 1'b1, bStall = 1'b0, bRedir = 1'b0, bHalt = 1'b0, bResume = 1'b0;
    logic [31:0] bTgt = '0;
    logic        bPcRst, bPcEn, bBranchSel, bIfIdEn, bIfIdFlush, bHalted;
    logic [31:0] bBranchVal;
    logic [2:0]  bStallCnt, bRedirCnt;
    logic [31:0] bPc = '0;

    fetch_ctrl #(.XLEN(32), .BOOT_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(3)) dutB (
        .clk(clk), .rst(bRst), .stallReq(bStall), .redirectReq(bRedir),
        .redirectTarget(bTgt), .haltReq(bHalt), .resumeReq(bResume),
        .pcRst(bPcRst), .pcEn(bPcEn), .branchSel(bBranchSel), .branchVal(bBranchVal),
        .ifIdEn(bIfIdEn), .ifIdFlush(bIfIdFlush), .halted(bHalted),
        .stallCnt(bStallCnt), .redirCnt(bRedirCnt)
    );

    // PC register models driven by the controller outputs.
    always @(posedge clk) begin
        if (aPcRst)     aPc <= '0;
        else if (aPcEn) aPc <= aBranchSel ? aBranchVal : aPc + 32'd4;
        if (bPcRst)     bPc <= '0;
        else if (bPcEn) bPc <= bBranchSel ? bBranchVal : bPc + 32'd4;
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // ================= instance A =================
        cyc();                                   // reset edge
        settle();
        checkEq("rstPcRst",     aPcRst,     1);
        checkEq("rstPcEn",      aPcEn,      0);
        checkEq("rstIfIdEn",    aIfIdEn,    0);
        checkEq("rstIfIdFlush", aIfIdFlush, 1);
        checkEq("rstHalted",    aHalted,    0);
        checkEq("rstBranchVal", aBranchVal, 0);
        checkEq("rstStallCnt",  aStallCnt,  0);
        checkEq("rstRedirCnt",  aRedirCnt,  0);

        aRst = 1'b0;
        settle();
        checkEq("boot1PcRst", aPcRst, 1);
        checkEq("boot1PcEn",  aPcEn,  0);
        cyc();
        checkEq("boot2PcRst", aPcRst, 1);
        cyc();
        checkEq("run1PcRst",     aPcRst,     0);
        checkEq("run1PcEn",      aPcEn,      1);
        checkEq("run1BranchSel", aBranchSel, 0);
        checkEq("run1IfIdFlush", aIfIdFlush, 0);
        checkEq("pc0", aPc, 32'h0);
        cyc();
        checkEq("pc4", aPc, 32'h4);
        cyc();
        checkEq("pc8", aPc, 32'h8);

        // three stall cycles
        aStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checkEq("stallPcEn",   aPcEn,   0);
            checkEq("stallIfIdEn", aIfIdEn, 0);
            cyc();
        end
        aStall = 1'b0;
        settle();
        checkEq("postStallPcEn", aPcEn,     1);
        checkEq("stallHoldPc",   aPc,       32'h8);
        checkEq("stallCnt3",     aStallCnt, 3);

        // redirect beats a simultaneous stall
        aStall = 1'b1; aRedir = 1'b1; aTgt = 32'h100;
        settle();
        checkEq("redirBranchSel", aBranchSel, 1);
        checkEq("redirBranchVal", aBranchVal, 32'h100);
        checkEq("redirIfIdFlush", aIfIdFlush, 1);
        checkEq("redirPcEn",      aPcEn,      1);
        cyc();
        aStall = 1'b0; aRedir = 1'b0;
        settle();
        checkEq("redirPc",        aPc,        32'h100);
        checkEq("redirCnt1",      aRedirCnt,  1);
        checkEq("redirStallSame", aStallCnt,  3);
        checkEq("noFlushTail",    aIfIdFlush, 0);
        checkEq("noFlushPcEn",    aPcEn,      1);
        cyc();
        checkEq("pc104", aPc, 32'h104);

        // halt, redirects while halted (last one wins), resume
        aHalt = 1'b1;
        settle();
        checkEq("haltReqPcEn",   aPcEn,   0);
        checkEq("haltReqHalted", aHalted, 0);
        cyc();
        aHalt = 1'b0;
        settle();
        checkEq("halted1", aHalted, 1);
        aRedir = 1'b1; aTgt = 32'h180;
        cyc();
        aTgt = 32'h200;
        aStall = 1'b1;
        cyc();
        aRedir = 1'b0; aStall = 1'b0;
        settle();
        checkEq("haltHoldPc",     aPc,       32'h104);
        checkEq("haltStallIgn",   aStallCnt, 3);
        checkEq("haltPcEn",       aPcEn,     0);
        aResume = 1'b1;
        cyc();
        aResume = 1'b0;
        settle();
        checkEq("resumeHalted",    aHalted,    0);
        checkEq("resumeBranchSel", aBranchSel, 1);
        checkEq("resumeBranchVal", aBranchVal, 32'h200);
        checkEq("resumePcEn",      aPcEn,      1);
        cyc();
        checkEq("resumePc",  aPc,       32'h200);
        checkEq("redirCnt2", aRedirCnt, 2);

        // reset in the middle of HALT
        aHalt = 1'b1;
        cyc();
        aHalt = 1'b0;
        settle();
        checkEq("halted2", aHalted, 1);
        aRst = 1'b1;
        settle();
        checkEq("rstHaltHalted", aHalted, 0);
        checkEq("rstHaltPcRst",  aPcRst,  1);
        cyc();
        aRst = 1'b0;
        settle();
        checkEq("rst2StallCnt", aStallCnt, 0);
        checkEq("rst2RedirCnt", aRedirCnt, 0);
        checkEq("rst2Halted",   aHalted,   0);
        checkEq("rst2PcRst",    aPcRst,    1);

        // redirect captured during BOOT is replayed in the first RUN cycle
        aRedir = 1'b1; aTgt = 32'h300;
        cyc();
        aRedir = 1'b0;
        cyc();
        checkEq("bootPendPcRst",     aPcRst,     0);
        checkEq("bootPendBranchSel", aBranchSel, 1);
        checkEq("bootPendBranchVal", aBranchVal, 32'h300);

        // ================= instance B =================
        bRst = 1'b0;
        settle();
        checkEq("bBootPcRst", bPcRst, 1);
        cyc();
        cyc();
        checkEq("bRun1PcEn", bPcEn, 1);

        // redirect to 0x40 with a three-cycle flush
        bRedir = 1'b1; bTgt = 32'h40;
        settle();
        checkEq("bRedirFlush",     bIfIdFlush, 1);
        checkEq("bRedirBranchSel", bBranchSel, 1);
        cyc();
        bRedir = 1'b0;
        settle();
        checkEq("bF1Flush", bIfIdFlush, 1);
        checkEq("bF1PcEn",  bPcEn,      0);
        checkEq("bF1Pc",    bPc,        32'h40);
        cyc();
        checkEq("bF2Flush", bIfIdFlush, 1);
        checkEq("bF2PcEn",  bPcEn,      0);
        checkEq("bF2Pc",    bPc,        32'h40);
        cyc();
        checkEq("bF3Flush", bIfIdFlush, 0);
        checkEq("bF3PcEn",  bPcEn,      1);
        checkEq("bF3Pc",    bPc,        32'h40);
        cyc();
        checkEq("bPc44", bPc, 32'h44);

        // halt requested during flush: taken at flush end, stall ignored
        bRedir = 1'b1; bTgt = 32'h80;
        cyc();
        bRedir = 1'b0; bHalt = 1'b1; bStall = 1'b1;
        settle();
        checkEq("bFlushHaltPend", bHalted, 0);
        cyc();
        cyc();
        bHalt = 1'b0; bStall = 1'b0;
        settle();
        checkEq("bHaltAfterFlush", bHalted,   1);
        checkEq("bFlushStallIgn",  bStallCnt, 0);
        checkEq("bRedirCnt2",      bRedirCnt, 2);
        checkEq("bHaltPc",         bPc,       32'h80);
        bResume = 1'b1;
        cyc();
        bResume = 1'b0;
        settle();
        checkEq("bResumeHalted",    bHalted,    0);
        checkEq("bResumeBranchSel", bBranchSel, 0);
        checkEq("bResumePcEn",      bPcEn,      1);

        // stall counter saturation (3-bit counter tops out at 7)
        bStall = 1'b1;
        repeat (7) cyc();
        checkEq("bStallCnt7", bStallCnt, 7);
        repeat (3) cyc();
        bStall = 1'b0;
        settle();
        checkEq("bStallSat", bStallCnt, 7);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
